// File: rtl/fir_col_gen.sv
// Vertical 3-tap column generator: keeps the two previous lines in an external
// dual-port SRAM (read-modify-write) and emits edge-replicated vertical columns.
module fir_col_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [CNT_WIDTH-1:0]    h_size_i,
  input  logic [CNT_WIDTH-1:0]    v_size_i,
  output logic                    ready_o,
  output logic                    drop_o,
  output logic                    rd_en_o,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  input  logic [2*DATA_WIDTH-1:0] rd_data_i,
  output logic                    wr_en_o,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [2*DATA_WIDTH-1:0] wr_data_o,
  output logic                    col_valid_o,
  output logic [3*DATA_WIDTH-1:0] col_data_o,
  output logic                    col_sol_o,
  output logic                    col_eol_o,
  output logic                    col_eof_o
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    x;
  logic [CNT_WIDTH-1:0]    y;
  logic [CNT_WIDTH-1:0]    h_lat;
  logic [CNT_WIDTH-1:0]    v_lat;
  logic [CNT_WIDTH-1:0]    h_cur;
  logic                    ready;
  logic                    drop;
  logic                    accept;
  logic                    x_last;
  logic                    y_last;
  logic                    emit;

  // first pipeline stage: aligned with rd_data_i
  logic                    s1_emit;
  logic                    s1_flush;
  logic                    s1_fill;
  logic [DATA_WIDTH-1:0]   s1_pix;
  logic                    s1_sol;
  logic                    s1_eol;
  logic                    s1_eof;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  // output stage
  logic                    col_valid;
  logic [3*DATA_WIDTH-1:0] col_data;
  logic                    col_sol;
  logic                    col_eol;
  logic                    col_eof;

  logic [DATA_WIDTH-1:0]   tap [3];
  logic [3*DATA_WIDTH-1:0] col_next;

  assign accept = ce_i & ready;
  // The frame's first pixel compares against the size being latched this cycle.
  assign h_cur  = (state == FILL && x == '0) ? h_size_i : h_lat;
  assign x_last = (x == h_cur - CNT_WIDTH'(1));
  assign y_last = (y == v_lat - CNT_WIDTH'(1));
  assign emit   = (state == RUN && accept) || (state == FLUSH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      x     <= '0;
      y     <= '0;
      h_lat <= '0;
      v_lat <= '0;
      ready <= 1'b0;
      drop  <= 1'b0;
    end else begin
      drop <= ce_i & ~ready;
      case (state)
        FILL: begin
          ready <= 1'b1;
          if (accept) begin
            if (x == '0) begin
              h_lat <= h_size_i;
              v_lat <= v_size_i;
            end
            if (x_last) begin
              x <= '0;
              if (v_lat > CNT_WIDTH'(1)) begin
                state <= RUN;
                y     <= CNT_WIDTH'(1);
              end else begin
                state <= FLUSH;
                ready <= 1'b0;
              end
            end else begin
              x <= x + CNT_WIDTH'(1);
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (x_last) begin
              x <= '0;
              if (y_last) begin
                state <= FLUSH;
                ready <= 1'b0;
              end else begin
                y <= y + CNT_WIDTH'(1);
              end
            end else begin
              x <= x + CNT_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (x_last) begin
            x     <= '0;
            y     <= '0;
            state <= FILL;
            ready <= 1'b1;
          end else begin
            x <= x + CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= FILL;
          x     <= '0;
          y     <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_emit  <= 1'b0;
      s1_flush <= 1'b0;
      s1_fill  <= 1'b0;
      s1_pix   <= '0;
      s1_sol   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
    end else begin
      s1_emit  <= emit;
      s1_flush <= (state == FLUSH);
      s1_fill  <= (state == FILL);
      s1_pix   <= data_i;
      s1_sol   <= (x == '0);
      s1_eol   <= x_last;
      s1_eof   <= (state == FLUSH) && x_last;
      wr_en    <= accept && (state != FLUSH);
      if (accept) begin
        wr_addr <= x[ADDR_WIDTH-1:0];
      end
    end
  end

  // Column lanes, top in the low bits; FLUSH replicates the bottom edge.
  assign tap[0] = rd_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
  assign tap[1] = rd_data_i[DATA_WIDTH-1:0];
  assign tap[2] = s1_flush ? rd_data_i[DATA_WIDTH-1:0] : s1_pix;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign col_next[gi*DATA_WIDTH +: DATA_WIDTH] = tap[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_valid <= 1'b0;
      col_data  <= '0;
      col_sol   <= 1'b0;
      col_eol   <= 1'b0;
      col_eof   <= 1'b0;
    end else begin
      col_valid <= s1_emit;
      col_sol   <= s1_emit & s1_sol;
      col_eol   <= s1_emit & s1_eol;
      col_eof   <= s1_emit & s1_eof;
      if (s1_emit) begin
        col_data <= col_next;
      end
    end
  end

  assign ready_o     = ready;
  assign drop_o      = drop;
  assign rd_en_o     = emit;
  assign rd_addr_o   = emit ? x[ADDR_WIDTH-1:0] : '0;
  assign wr_en_o     = wr_en;
  assign wr_addr_o   = wr_addr;
  // FILL seeds both line slots with the pixel, so line 0 replicates upward.
  assign wr_data_o   = !wr_en  ? '0 :
                       s1_fill ? {s1_pix, s1_pix} :
                                 {rd_data_i[DATA_WIDTH-1:0], s1_pix};
  assign col_valid_o = col_valid;
  assign col_data_o  = col_data;
  assign col_sol_o   = col_sol;
  assign col_eol_o   = col_eol;
  assign col_eof_o   = col_eof;

endmodule

// File: tb/tb_fir_col_gen.sv
// Scoreboard bench for fir_col_gen: expected columns come from a 2D image model
// with edge replication; a behavioural SRAM sits on the line-buffer ports.
module tb_fir_col_gen;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int CW = 12;

  typedef struct packed {
    logic [3*DW-1:0] data;
    logic            sol;
    logic            eol;
    logic            eof;
  } col_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce_i;
  logic [DW-1:0] data_i;
  logic [CW-1:0] h_size_i;
  logic [CW-1:0] v_size_i;
  logic          ready_o;
  logic          drop_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [2*DW-1:0] rd_data;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [2*DW-1:0] wr_data_o;
  logic          col_valid_o;
  logic [3*DW-1:0] col_data_o;
  logic          col_sol_o;
  logic          col_eol_o;
  logic          col_eof_o;

  logic [2*DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int drop_cnt = 0;
  int low_cnt = 0;
  int rd0, wr0, drop0, low0;
  int first_acc, last_acc, prev_last;
  col_t exp_q[$];
  int   exp_t[$];
  col_t seen_q[$];
  col_t ref_q[$];
  col_t mon_e;
  int   mon_t;
  col_t sv;
  col_t rv;

  fir_col_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ce_i(ce_i), .data_i(data_i),
    .h_size_i(h_size_i), .v_size_i(v_size_i), .ready_o(ready_o), .drop_o(drop_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .col_valid_o(col_valid_o), .col_data_o(col_data_o),
    .col_sol_o(col_sol_o), .col_eol_o(col_eol_o), .col_eof_o(col_eof_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rd_en_o) rd_data <= mem[rd_addr_o];
    if (wr_en_o) mem[wr_addr_o] <= wr_data_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int y, input int x);
    return DW'(base + 16 * y + x);
  endfunction

  function automatic col_t mk_col(input int base, input int r, input int x, input int h, input int v);
    col_t c;
    int rt;
    int rb;
    rt = (r > 0) ? r - 1 : 0;
    rb = (r < v - 1) ? r + 1 : v - 1;
    c.data = {pix(base, rb, x), pix(base, r, x), pix(base, rt, x)};
    c.sol  = (x == 0);
    c.eol  = (x == h - 1);
    c.eof  = (r == v - 1) && (x == h - 1);
    return c;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 64'({ready_o, drop_o, rd_en_o, wr_en_o, col_valid_o,
                              col_sol_o, col_eol_o, col_eof_o, rd_addr_o, wr_addr_o}), 64'(0));
    check({tag, "_data"}, 64'({wr_data_o, col_data_o}), 64'(0));
  endtask

  // Present one pixel (optionally after random idle cycles) and wait for acceptance.
  task automatic send(input logic [DW-1:0] p, input bit gaps, output int acc);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        ce_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    ce_i   = 1'b1;
    data_i = p;
    acc    = -1;
    for (int n = 0; n < 200 && acc < 0; n++) begin
      @(negedge clk);
      if (ready_o) acc = cyc;
      @(posedge clk); #1;
    end
    check("accept", 64'(acc >= 0), 64'(1));
  endtask

  task automatic run_frame(input int h, input int v, input int base, input bit gaps,
                           input bit chain, input int chg_idx, input int nh, input int nv,
                           input int stop_after);
    int acc;
    int idx;
    h_size_i = CW'(h);
    v_size_i = CW'(v);
    acc = 0;
    for (int y = 0; y < v; y++) begin
      for (int x = 0; x < h; x++) begin
        idx = y * h + x;
        if (stop_after >= 0 && idx >= stop_after) begin
          ce_i = 1'b0;
          return;
        end
        send(pix(base, y, x), gaps, acc);
        if (idx == 0) first_acc = acc;
        if (idx == chg_idx) begin
          h_size_i = CW'(nh);
          v_size_i = CW'(nv);
        end
        if (y >= 1) begin
          exp_q.push_back(mk_col(base, y - 1, x, h, v));
          exp_t.push_back(acc + 2);
        end
      end
    end
    last_acc = acc;
    for (int x = 0; x < h; x++) begin
      exp_q.push_back(mk_col(base, v - 1, x, h, v));
      exp_t.push_back(acc + 3 + x);
    end
    if (!chain) ce_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    rd0   = rd_cnt;
    wr0   = wr_cnt;
    drop0 = drop_cnt;
    low0  = low_cnt;
    seen_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    ce_i     = 1'b0;
    data_i   = '0;
    h_size_i = CW'(4);
    v_size_i = CW'(3);

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (!ready_o) low_cnt++;
          if (drop_o)   drop_cnt++;
          if (rd_en_o)  rd_cnt++;
          if (wr_en_o)  wr_cnt++;
        end
        if (col_valid_o) begin
          seen_q.push_back({col_data_o, col_sol_o, col_eol_o, col_eof_o});
          check("col_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = exp_t.pop_front();
            $display("col cyc=%0d data=%06h sol=%0b eol=%0b eof=%0b", cyc, col_data_o,
                     col_sol_o, col_eol_o, col_eof_o);
            check("col_data", 64'(col_data_o), 64'(mon_e.data));
            check("col_flags", 64'({col_sol_o, col_eol_o, col_eof_o}),
                  64'({mon_e.sol, mon_e.eol, mon_e.eof}));
            check("col_latency", 64'(cyc), 64'(mon_t));
          end
        end
      end
    join_none

    // Reset
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_rise", 64'(ready_o), 64'(0));
    @(posedge clk); #1;
    check("ready_rise", 64'(ready_o), 64'(1));

    // 4x3 frame, ce held high
    snap();
    run_frame(4, 3, 0, 1'b0, 1'b0, -1, 0, 0, -1);
    drain();
    check("s1_count", 64'(seen_q.size()), 64'(12));
    sv = seen_q[1];
    check("s1_r0x1", 64'(sv.data), 64'(24'h110101));
    sv = seen_q[5];
    check("s1_r1x1", 64'(sv.data), 64'(24'h211101));
    sv = seen_q[11];
    check("s1_r2x3", 64'(sv), 64'({24'h232313, 3'b011}));
    check("s1_ready_low", 64'(low_cnt - low0), 64'(4));
    check("s1_reads", 64'(rd_cnt - rd0), 64'(12));
    check("s1_writes", 64'(wr_cnt - wr0), 64'(12));
    check("s1_drops", 64'(drop_cnt - drop0), 64'(0));
    ref_q = seen_q;

    // 2x1 frame: only FLUSH reads
    snap();
    run_frame(2, 1, 'hA0, 1'b0, 1'b0, -1, 0, 0, -1);
    drain();
    check("s2_count", 64'(seen_q.size()), 64'(2));
    sv = seen_q[0];
    check("s2_col0", 64'(sv), 64'({24'hA0A0A0, 3'b100}));
    sv = seen_q[1];
    check("s2_col1", 64'(sv), 64'({24'hA1A1A1, 3'b011}));
    check("s2_reads", 64'(rd_cnt - rd0), 64'(2));
    check("s2_writes", 64'(wr_cnt - wr0), 64'(2));

    // 4x3 frame with random ce gaps
    snap();
    run_frame(4, 3, 0, 1'b1, 1'b0, -1, 0, 0, -1);
    drain();
    check("s3_count", 64'(seen_q.size()), 64'(12));
    for (int i = 0; i < 12 && i < seen_q.size(); i++) begin
      sv = seen_q[i];
      rv = ref_q[i];
      check("s3_same", 64'(sv), 64'(rv));
    end

    // ce held high through FLUSH into the next frame
    snap();
    run_frame(4, 3, 'h30, 1'b0, 1'b1, -1, 0, 0, -1);
    prev_last = last_acc;
    run_frame(4, 3, 'h60, 1'b0, 1'b0, -1, 0, 0, -1);
    drain();
    check("s4_drops", 64'(drop_cnt - drop0), 64'(4));
    check("s4_writes", 64'(wr_cnt - wr0), 64'(24));
    check("s4_next_x0", 64'(first_acc), 64'(prev_last + 5));
    check("s4_ready_low", 64'(low_cnt - low0), 64'(8));

    // sizes changed mid-frame, back-to-back 3x2 frame
    snap();
    run_frame(4, 3, 'h10, 1'b0, 1'b1, 5, 3, 2, -1);
    run_frame(3, 2, 'h80, 1'b0, 1'b0, -1, 0, 0, -1);
    drain();
    check("s5_count", 64'(seen_q.size()), 64'(18));
    check("s5_writes", 64'(wr_cnt - wr0), 64'(18));

    // reset at RUN y=1, x=2
    snap();
    run_frame(4, 3, 0, 1'b0, 1'b0, -1, 0, 0, 6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_t.delete();
    check_zero("mid_reset");
    repeat (5) @(posedge clk);
    #1;
    check("s6_cols_before_abort", 64'(seen_q.size()), 64'(1));
    snap();
    run_frame(4, 3, 0, 1'b0, 1'b0, -1, 0, 0, -1);
    drain();
    check("s6_count", 64'(seen_q.size()), 64'(12));
    for (int i = 0; i < 12 && i < seen_q.size(); i++) begin
      sv = seen_q[i];
      rv = ref_q[i];
      check("s6_same", 64'(sv), 64'(rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
